seven_seg_scan_ctrl: RTL and testbench
======================================

// Module: seven_seg_scan_ctrl
// PURPOSE
//  Parametrised multiplexed 7-segment scan controller: time-slices NUM_DIGITS common-anode digits.
//  Adds hex decode, DP, per-digit blanking, frame-coherent data capture and anode dead time.
//  Sits between datapath/ASM display registers and the board's an/seg/dp pins.
//  Default Clk is 5 MHz.
// PARAMETERS
//  NUM_DIGITS   4   digits scanned, 1..8
//  CNT_WIDTH    12  prescaler width; slot length = 2**CNT_WIDTH Clk cycles
//  BLANK_SLOTS  1   all-off slots appended per frame, 0..3
//  DEAD_CYCLES  8   anodes forced off at start of every slot; must be < 2**CNT_WIDTH
// PORTS
//  Clk          in   1             system clock, rising edge
//  reset_n      in   1             asynchronous, active-low reset
//  digits       in   4*NUM_DIGITS  hex nibbles; digit i = digits[4i+3:4i]
//  dp           in   NUM_DIGITS    decimal point per digit, 1 = lit
//  digit_en     in   NUM_DIGITS    1 = digit shown, 0 = anode held off in its slot
//  bright       in   4             duty level; present only with SEVSEG_DIM_EN
//  an           out  NUM_DIGITS    anodes, active-low; bit i drives digit i
//  seg          out  7             segments, active-low, {g,f,e,d,c,b,a}
//  dp_n         out  1             decimal point, active-low
//  frame_start  out  1             1-cycle pulse when shadow data is captured
// BEHAVIOUR
//  - Reset (reset_n=0, async): an all 1, seg=7'h7F, dp_n=1, frame_start=0, cnt=0, slot=0.
//    Shadow regs are cleared to 0.
//  - cnt counts 0..2**CNT_WIDTH-1 and wraps. When it wraps, slot advances.
//    slot runs 0..NUM_DIGITS+BLANK_SLOTS-1, then returns to 0.
//  - Capture: on the cycle cnt and slot both go to 0, digits/dp/digit_en load into shadow regs.
//    The same capture fires on the first clock after reset release.
//    frame_start=1 for that cycle only. Input changes mid-frame never reach the outputs.
//  - Outputs are registered: pins reflect the (cnt,slot) value of the previous cycle.
//    One cycle latency.
//  - For slot s < NUM_DIGITS: seg = hex7(shadow nibble s) and dp_n = ~shadow_dp[s].
//    an[s]=0 only when cnt >= DEAD_CYCLES, shadow_en[s]=1 and the dim gate is open.
//    All other an bits are 1.
//  - Blank slots (s >= NUM_DIGITS): an all 1, seg=7'h7F, dp_n=1.
//  - During the dead time seg/dp already hold the new digit and all anodes are 1.
//    At most one an bit is 0 in any cycle, and it is never 0 across a slot boundary.
//  - hex7 (active-low): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E.
//  - Frame length = (NUM_DIGITS+BLANK_SLOTS)*2**CNT_WIDTH cycles. Default is 20480 (~244 Hz at 5 MHz).
//  - Reset asserted mid-slot returns everything to the reset state immediately. No partial frame resumes.
// CONFIGURATION
//  - SEVSEG_DIM_EN defined:
//    - The bright port exists. Let top = cnt[CNT_WIDTH-1 -: 4].
//    - The dim gate is open only while top < bright, so duty is bright/16 of the slot.
//    - bright=0: display dark. bright is sampled into the shadow regs at frame capture.
//    - Dead time still applies.
//  - SEVSEG_DIM_EN undefined: no bright port, dim gate always open (full duty minus dead time).
// TESTING (bench uses CNT_WIDTH=4, DEAD_CYCLES=2, NUM_DIGITS=4, BLANK_SLOTS=1)
//  1. Reset: hold reset_n=0 and toggle Clk.
//     -> an=4'hF, seg=7'h7F, dp_n=1, frame_start=0. Release -> frame_start pulses once.
//  2. Scan: digits=16'h1234, dp=4'b0100, digit_en=4'hF.
//     -> an=1110/seg=7'h19 (slot 0), 1101/30, 1011/24 with dp_n=0, 0111/79, then 16 cycles of 1111.
//     Frame period 80 cycles.
//  3. Dead time: at every slot boundary all anodes read 1 for exactly 2 cycles.
//     Assert an is never 0 on two different bits in any cycle.
//  4. Coherence: change digits to 16'hABCD during slot 1.
//     -> the current frame still shows 1234; the next frame (after frame_start) shows ABCD.
//  5. Blanking: digit_en=4'b1010.
//     -> an[0] and an[2] stay 1 for the whole frame; digits 1 and 3 scan normally.
//  6. Mid-slot reset: pull reset_n low in slot 2, cnt=7.
//     -> outputs hit reset values with no clock edge; after release, scanning restarts at slot 0.
//     With SEVSEG_DIM_EN and bright=4: an active 4 of each 16 cycles, minus dead time.
//     With bright=0: an stays all 1.

Source files
------------

// File: rtl/seven_seg_scan_ctrl.sv
// rtl/seven_seg_scan_ctrl.sv - multiplexed common-anode 7-segment scan controller
// Optional duty-cycle dimming through the bright port when SEVSEG_DIM_EN is defined.
module seven_seg_scan_ctrl #(
    parameter int NUM_DIGITS  = 4,
    parameter int CNT_WIDTH   = 12,
    parameter int BLANK_SLOTS = 1,
    parameter int DEAD_CYCLES = 8
) (
    input  logic                    Clk,
    input  logic                    reset_n,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   digit_en,
`ifdef SEVSEG_DIM_EN
    input  logic [3:0]              bright,
`endif
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp_n,
    output logic                    frame_start
);

    localparam int NUM_SLOTS = NUM_DIGITS + BLANK_SLOTS;
    localparam int SLOT_W    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam logic [SLOT_W-1:0]    LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);
    localparam logic [CNT_WIDTH-1:0] DEAD_END  = CNT_WIDTH'(DEAD_CYCLES);

    typedef enum logic {
        ST_SYNC,
        ST_SCAN
    } state_t;

    state_t                  state;
    logic [CNT_WIDTH-1:0]    cnt;
    logic [SLOT_W-1:0]       slot;
    logic [4*NUM_DIGITS-1:0] sh_digits;
    logic [NUM_DIGITS-1:0]   sh_dp;
    logic [NUM_DIGITS-1:0]   sh_en;
`ifdef SEVSEG_DIM_EN
    logic [3:0]              sh_bright;
`endif

    logic                  cnt_last;
    logic                  capture;
    logic                  dim_open;
    logic                  live;
    logic [NUM_DIGITS-1:0] an_nxt;
    logic [6:0]            seg_nxt;
    logic                  dp_nxt;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0:    hex7 = 7'h40;
            4'h1:    hex7 = 7'h79;
            4'h2:    hex7 = 7'h24;
            4'h3:    hex7 = 7'h30;
            4'h4:    hex7 = 7'h19;
            4'h5:    hex7 = 7'h12;
            4'h6:    hex7 = 7'h02;
            4'h7:    hex7 = 7'h78;
            4'h8:    hex7 = 7'h00;
            4'h9:    hex7 = 7'h10;
            4'hA:    hex7 = 7'h08;
            4'hB:    hex7 = 7'h03;
            4'hC:    hex7 = 7'h46;
            4'hD:    hex7 = 7'h21;
            4'hE:    hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    assign cnt_last = (cnt == {CNT_WIDTH{1'b1}});
    // Sync state covers the first clock after reset; otherwise capture as (cnt,slot) wraps to (0,0).
    assign capture  = (state == ST_SYNC) || (cnt_last && (slot == LAST_SLOT));

`ifdef SEVSEG_DIM_EN
    assign dim_open = (cnt[CNT_WIDTH-1 -: 4] < sh_bright);
`else
    assign dim_open = 1'b1;
`endif

    assign live = (cnt >= DEAD_END) && dim_open;

    always_comb begin
        an_nxt  = '1;
        seg_nxt = 7'h7F;
        dp_nxt  = 1'b1;
        if (state == ST_SCAN) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (slot == SLOT_W'(i)) begin
                    seg_nxt   = hex7(sh_digits[4*i +: 4]);
                    dp_nxt    = ~sh_dp[i];
                    an_nxt[i] = ~(sh_en[i] && live);
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_SYNC;
            cnt         <= '0;
            slot        <= '0;
            sh_digits   <= '0;
            sh_dp       <= '0;
            sh_en       <= '0;
`ifdef SEVSEG_DIM_EN
            sh_bright   <= '0;
`endif
            an          <= '1;
            seg         <= 7'h7F;
            dp_n        <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            an          <= an_nxt;
            seg         <= seg_nxt;
            dp_n        <= dp_nxt;
            frame_start <= capture;
            if (capture) begin
                sh_digits <= digits;
                sh_dp     <= dp;
                sh_en     <= digit_en;
`ifdef SEVSEG_DIM_EN
                sh_bright <= bright;
`endif
            end
            case (state)
                ST_SYNC: begin
                    state <= ST_SCAN;
                    cnt   <= '0;
                    slot  <= '0;
                end
                default: begin
                    cnt <= cnt + CNT_WIDTH'(1);
                    if (cnt_last) begin
                        slot <= (slot == LAST_SLOT) ? '0 : slot + SLOT_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb/tb_seven_seg_scan_ctrl.sv - directed bench for seven_seg_scan_ctrl
// Small configuration: 4 digits, 16-cycle slots, 1 blank slot, 2 dead cycles, 80-cycle frame.
module tb_seven_seg_scan_ctrl;

    localparam int ND       = 4;
    localparam int CW       = 4;
    localparam int BS       = 1;
    localparam int DC       = 2;
    localparam int SLOT_LEN = 16;
    localparam int FRAME    = 80;

    logic        Clk = 1'b0;
    logic        reset_n;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  digit_en;
`ifdef SEVSEG_DIM_EN
    logic [3:0]  bright;
    logic [3:0]  e_bright;
`endif
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp_n;
    logic        frame_start;

    int n_checks = 0;
    int n_fail   = 0;

    logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic [15:0] e_digits;
    logic [3:0]  e_dp;
    logic [3:0]  e_en;

    seven_seg_scan_ctrl #(
        .NUM_DIGITS  (ND),
        .CNT_WIDTH   (CW),
        .BLANK_SLOTS (BS),
        .DEAD_CYCLES (DC)
    ) dut (
        .Clk         (Clk),
        .reset_n     (reset_n),
        .digits      (digits),
        .dp          (dp),
        .digit_en    (digit_en),
`ifdef SEVSEG_DIM_EN
        .bright      (bright),
`endif
        .an          (an),
        .seg         (seg),
        .dp_n        (dp_n),
        .frame_start (frame_start)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pins at frame position k show slot k/16, in-slot count k%16.
    task automatic check_pins(input int k);
        int         s;
        int         c;
        logic       gate;
        logic [3:0] ea;
        logic [6:0] es;
        logic       ed;
        s    = k / SLOT_LEN;
        c    = k % SLOT_LEN;
        gate = 1'b1;
`ifdef SEVSEG_DIM_EN
        gate = (c < int'(e_bright));
`endif
        ea = 4'hF;
        es = 7'h7F;
        ed = 1'b1;
        if (s < ND) begin
            es = hex_tab[e_digits[4*s +: 4]];
            ed = ~e_dp[s];
            if (c >= DC && e_en[s] && gate) ea[s] = 1'b0;
        end
        check($sformatf("an k=%0d", k), 32'(an), 32'(ea));
        check($sformatf("seg k=%0d", k), 32'(seg), 32'(es));
        check($sformatf("dp_n k=%0d", k), 32'(dp_n), 32'(ed));
        check($sformatf("an_onehot k=%0d", k), 32'($countones(~an) <= 1), 32'd1);
    endtask

    task automatic run_frame(input int upto, input int chg_k,
                             input logic [15:0] nd, input logic [3:0] nen);
        for (int k = 0; k < upto; k++) begin
            @(negedge Clk);
            check_pins(k);
            check($sformatf("frame_start k=%0d", k), 32'(frame_start), 32'(k == FRAME - 1));
            if (k == chg_k) begin
                digits   = nd;
                digit_en = nen;
            end
        end
    endtask

    task automatic wait_fs();
        int n;
        n = 0;
        while (frame_start !== 1'b1 && n < 200) begin
            @(negedge Clk);
            n++;
        end
        check("frame_start_seen", 32'(frame_start), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        digits   = 16'h1234;
        dp       = 4'b0100;
        digit_en = 4'hF;
`ifdef SEVSEG_DIM_EN
        bright   = 4'd4;
        e_bright = 4'd4;
`endif
        reset_n  = 1'b0;
        repeat (3) @(negedge Clk);
        check("rst_an", 32'(an), 32'hF);
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_dp_n", 32'(dp_n), 32'd1);
        check("rst_frame_start", 32'(frame_start), 32'd0);

        reset_n = 1'b1;
        @(negedge Clk);
        check("fs_after_release", 32'(frame_start), 32'd1);
        check("an_after_release", 32'(an), 32'hF);
        check("seg_after_release", 32'(seg), 32'h7F);

        e_digits = 16'h1234;
        e_dp     = 4'b0100;
        e_en     = 4'hF;
        run_frame(FRAME, -1, 16'h1234, 4'hF);

        // New digits arrive in slot 1; this frame must still show 1234.
        run_frame(FRAME, 20, 16'hABCD, 4'hF);
        e_digits = 16'hABCD;
        run_frame(FRAME, 5, 16'hABCD, 4'b1010);
        e_en = 4'b1010;
        run_frame(FRAME, 5, 16'hABCD, 4'hF);
        e_en = 4'hF;

        // Stop with the counter state at slot 2, cnt 7, then reset asynchronously.
        run_frame(39, -1, 16'hABCD, 4'hF);
        reset_n = 1'b0;
        #1;
        check("mid_rst_an", 32'(an), 32'hF);
        check("mid_rst_seg", 32'(seg), 32'h7F);
        check("mid_rst_dp_n", 32'(dp_n), 32'd1);
        check("mid_rst_frame_start", 32'(frame_start), 32'd0);
        digits = 16'h0F9E;
        dp     = 4'b0001;
        repeat (2) @(negedge Clk);
        check("mid_rst_hold_an", 32'(an), 32'hF);
        reset_n = 1'b1;
        wait_fs();
        e_digits = 16'h0F9E;
        e_dp     = 4'b0001;
        run_frame(FRAME, -1, 16'h0F9E, 4'hF);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
